// File: rtl/tbb_seq_pkg.sv
// Shared types and constants for the TBB1143 register-write sequencer.
// Command layout is {is_short, addr, val}; phase selects which nibble is on the bus.
package tbb_seq_pkg;

    localparam int REG_W = 4;
    localparam int VAL_W = 8;
    localparam int CMD_W = 1 + REG_W + VAL_W;

    localparam logic [1:0] PH_ADDR = 2'd0;
    localparam logic [1:0] PH_DLO  = 2'd1;
    localparam logic [1:0] PH_DHI  = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    typedef struct packed {
        logic             is_short;
        logic [REG_W-1:0] addr;
        logic [VAL_W-1:0] val;
    } cmd_t;

    function automatic logic [3:0] cmd_nibble(input cmd_t c, input logic [1:0] ph);
        case (ph)
            PH_ADDR: return c.addr;
            PH_DLO:  return c.val[3:0];
            default: return c.val[7:4];
        endcase
    endfunction

endpackage

// File: rtl/tbb_cmd_fifo.sv
// Command FIFO: power-of-two depth, combinational head, full/empty/level from registered state.
// A push while full is dropped even if a pop happens in the same cycle.
module tbb_cmd_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int W          = 13
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        push_i,
    input  logic [W-1:0]                din_i,
    input  logic                        pop_i,
    output logic [W-1:0]                dout_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [$clog2(FIFO_DEPTH):0] level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          push_ok, pop_ok;

    assign full_o  = (level_q == LW'(FIFO_DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/tbb_write_sequencer.sv
// Serializes queued register writes into timed A0/D/WR nibble cycles for the TBB1143 core.
// Optional shadow register file under TBB_SEQ_SHADOW_EN; all bus outputs are registered.
module tbb_write_sequencer
    import tbb_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        CMD_VALID,
    output logic                        CMD_READY,
    input  logic                        CMD_SHORT,
    input  logic [3:0]                  CMD_REG,
    input  logic [7:0]                  CMD_VAL,
    output logic [3:0]                  BUS_D,
    output logic                        BUS_A0,
    output logic                        BUS_WR,
    output logic                        BUSY,
    output logic [$clog2(FIFO_DEPTH):0] LEVEL
`ifdef TBB_SEQ_SHADOW_EN
    ,
    input  logic [3:0]                  SHADOW_ADDR,
    output logic [7:0]                  SHADOW_Q
`endif
);

    localparam int MAXC  = (SETUP_CYC > STROBE_CYC) ?
                           ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                           ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    logic             fifo_full, fifo_empty, fifo_pop;
    logic [CMD_W-1:0] fifo_dout;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       phase_q, phase_d;
    cmd_t             cmd_q, cmd_d;
    logic             bus_a0_q, bus_a0_d, bus_wr_q, bus_wr_d;
    logic [3:0]       bus_d_q, bus_d_d;

    tbb_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .W(CMD_W)) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .push_i  (CMD_VALID),
        .din_i   ({CMD_SHORT, CMD_REG, CMD_VAL}),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (LEVEL)
    );

    assign CMD_READY = ~fifo_full;
    assign BUSY      = (state_q != IDLE) | (LEVEL != '0);
    assign BUS_A0    = bus_a0_q;
    assign BUS_D     = bus_d_q;
    assign BUS_WR    = bus_wr_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            phase_q  <= PH_ADDR;
            cmd_q    <= '0;
            bus_a0_q <= 1'b0;
            bus_d_q  <= '0;
            bus_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            cmd_q    <= cmd_d;
            bus_a0_q <= bus_a0_d;
            bus_d_q  <= bus_d_d;
            bus_wr_q <= bus_wr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        cmd_d    = cmd_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: if (!fifo_empty) begin
                fifo_pop = 1'b1;
                cmd_d    = cmd_t'(fifo_dout);
                phase_d  = PH_ADDR;
                state_d  = SETUP;
                cnt_d    = SETUP_LD;
            end
            SETUP: if (cnt_q == '0) begin
                state_d = STROBE;
                cnt_d   = STROBE_LD;
            end else cnt_d = cnt_q - 1'b1;
            STROBE: if (cnt_q == '0) begin
                state_d = HOLD;
                cnt_d   = HOLD_LD;
            end else cnt_d = cnt_q - 1'b1;
            HOLD: if (cnt_q == '0) begin
                if (phase_q == PH_ADDR || (phase_q == PH_DLO && !cmd_q.is_short)) begin
                    phase_d = phase_q + 1'b1;
                    state_d = SETUP;
                    cnt_d   = SETUP_LD;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end else cnt_d = cnt_q - 1'b1;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from next state so the registered bus lines up with the state.
    always_comb begin
        bus_a0_d = bus_a0_q;
        bus_d_d  = bus_d_q;
        bus_wr_d = (state_d == STROBE);
        if (state_d != IDLE) begin
            bus_a0_d = (phase_d == PH_ADDR);
            bus_d_d  = cmd_nibble(cmd_d, phase_d);
        end
    end

`ifdef TBB_SEQ_SHADOW_EN
    logic [7:0] shadow_q [16];
    logic       cmd_done;

    assign cmd_done = (state_q == HOLD) && (cnt_q == '0) &&
                      (phase_q == PH_DHI || (phase_q == PH_DLO && cmd_q.is_short));
    assign SHADOW_Q = shadow_q[SHADOW_ADDR];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) shadow_q[i] <= '0;
        end else if (cmd_done) begin
            shadow_q[cmd_q.addr] <= cmd_q.is_short ?
                                    {shadow_q[cmd_q.addr][7:4], cmd_q.val[3:0]} : cmd_q.val;
        end
    end
`else
    // No shadow storage in this build; the bus path is unaffected.
`endif

endmodule

// File: doc/tbb_write_sequencer.md
Name: tbb_write_sequencer

Overview:
- Front-end controller for the TBB1143 sound core's nibble-wide register bus (data_in[3:0], A0, WR).
- Accepts whole register-write commands from a host-side valid/ready port and buffers them in a small FIFO.
- Serializes each command into timed bus cycles: an address nibble with A0=1, then one or two data nibbles with A0=0.
- Guarantees setup/strobe/hold spacing so a host (MCU, song player) never bit-bangs WR directly.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2.
- SETUP_CYC, 1, CLK cycles that A0/D are stable before WR rises; ≥1.
- STROBE_CYC, 2, CLK cycles WR is held high; ≥1.
- HOLD_CYC, 1, CLK cycles A0/D are held after WR falls; ≥1.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous, active-high reset.
- CMD_VALID  input  1  host command valid.
- CMD_READY  output  1  FIFO can accept a command.
- CMD_SHORT  input  1  1 = write low value nibble only (4-bit registers).
- CMD_REG  input  4  target register index.
- CMD_VAL  input  8  register value.
- BUS_D  output  4  to core data_in[3:0].
- BUS_A0  output  1  to core A0; 1 = address nibble, 0 = data nibble.
- BUS_WR  output  1  to core WR strobe.
- BUSY  output  1  FIFO non-empty or bus transfer in progress.
- LEVEL  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous and active-high.
- Reset values (async): BUS_D=0, BUS_A0=0, BUS_WR=0, BUSY=0, LEVEL=0, CMD_READY=1. FIFO pointers cleared; FSM to IDLE.
- RST asserted mid-transfer aborts immediately, WR drops the same instant, and queued commands are discarded.
- FIFO entry = {SHORT, REG[3:0], VAL[7:0]}, 13 bits.
- Push occurs when CMD_VALID & CMD_READY on a rising CLK edge.
- CMD_READY = !full, from registered state only; no combinational path from any input.
- Push while full is not accepted; a pop in the same cycle does not free space for it.
- Push and pop in the same cycle when not full: LEVEL unchanged.
- Pointers wrap modulo FIFO_DEPTH. LEVEL counts 0..FIFO_DEPTH.
- FSM states: IDLE, SETUP, STROBE, HOLD. A phase register tracks 0 = address, 1 = data low, 2 = data high.
- IDLE: if FIFO is non-empty, pop the head into the working register, set phase=0, go to SETUP. This is the pop cycle.
- SETUP: drive BUS_A0=(phase==0) and BUS_D = REG, VAL[3:0] or VAL[7:4] by phase. BUS_WR=0. Stay SETUP_CYC cycles, then go to STROBE.
- STROBE: BUS_WR=1 with A0/D unchanged. Stay STROBE_CYC cycles, then go to HOLD.
- HOLD: BUS_WR=0 with A0/D unchanged. Stay HOLD_CYC cycles, then:
  - phase 0 → phase 1, SETUP.
  - phase 1 and SHORT=0 → phase 2, SETUP.
  - phase 1 and SHORT=1, or phase 2 → IDLE.
- In IDLE, BUS_A0/BUS_D keep their last values; BUS_WR is always 0.
- Cycles per command: 1 + 3·(SETUP+STROBE+HOLD) normal, 1 + 2·(…) short. With defaults: 13 and 9.
- Back-to-back commands get one IDLE cycle between the last HOLD and the next SETUP. WR never pulses on two consecutive cycles across nibbles.
- A single cycle counter is sized for max(SETUP_CYC, STROBE_CYC, HOLD_CYC). It reloads on every state change.
- BUSY = (state != IDLE) | (LEVEL != 0).
- Outputs are registered; no glitches on BUS_WR.

Optional Feature:
- Macro: TBB_SEQ_SHADOW_EN.
- Defined: adds ports SHADOW_ADDR (input, 4) and SHADOW_Q (output, 8), plus a 16×8 shadow register file.
  - At the end of a command's final HOLD, shadow[REG] is updated.
  - Short command: only bits [3:0] update; [7:4] are kept.
  - SHADOW_Q = shadow[SHADOW_ADDR], combinational read. Reset clears all entries to 0.
- Undefined: the ports and storage are absent; all other behaviour is identical.

Decomposition:
- Package tbb_seq_pkg holds:
  - FSM state enum (IDLE/SETUP/STROBE/HOLD).
  - Phase encoding constants (PH_ADDR=0, PH_DLO=1, PH_DHI=2).
  - Command field widths/offsets (CMD_W=13, REG_W=4, VAL_W=8).
- Sub-module tbb_cmd_fifo: synchronous FIFO with async RST, parameter FIFO_DEPTH, and full/empty/level outputs.
- The sequencer FSM and shadow logic live in the top.

Test Plan:
- Reset/idle: assert RST mid-STROBE of a command → BUS_WR=0 within the same timestep; BUSY=0, LEVEL=0, CMD_READY=1; nothing further written after release.
- Single normal write, defaults: push REG=5, VAL=0xA3.
  - Bus sequence: (A0=1, D=5), (A0=0, D=3), (A0=0, D=0xA).
  - Each nibble: WR high 2 cycles, preceded by 1 setup and followed by 1 hold cycle.
  - BUSY high for 13 cycles from the pop.
- Short write: push SHORT=1, REG=2, VAL=0x7C → exactly two WR pulses, (A0=1, D=2) then (A0=0, D=0xC).
- FIFO full: push 5 commands back-to-back with the sequencer stalled behind a long first command.
  - CMD_READY=0 once LEVEL=4; the 5th push is not taken until a pop; it is then accepted.
  - All commands appear on the bus in order.
- Timing parameters SETUP=2, STROBE=3, HOLD=2: measure A0/D stable ≥2 cycles before WR rise and ≥2 after fall; WR width exactly 3 cycles.
- With TBB_SEQ_SHADOW_EN: write REG=9 VAL=0x5E, then short REG=9 VAL=0x01 → SHADOW_ADDR=9 reads 0x5E, then 0x51.
